// File: rtl/mips_processor.sv
// mips_processor: single-cycle 32-bit MIPS-subset CPU.
//
// Every instruction is fetched, decoded, executed and written back within one
// clock cycle. The top level holds the instruction-fetch unit (with its
// byte-addressed instruction memory), the 32x32 register file, the ALU, the
// control decoder and a big-endian data memory.
//
// Ports:
//   clk    - the single clock, all state updates on its rising edge
//   reset  - synchronous active-high reset: PC and all registers go to zero
//
// Parameters:
//   IMEM_BYTES - instruction memory size in bytes (power of two)
//   DMEM_BYTES - data memory size in bytes (power of two)

package MipsPkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_PASSB
  } aluOp_e;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_LUI
  } extMode_e;

endpackage

// ByteStorage: read-only array of bytes returning one big-endian word.
// The array is preloaded from outside (e.g. by the testbench) and never written here.
//   wordAddr_i - word index into the array
//   word_o     - bytes[4*wordAddr_i] in bits 31:24 ... bytes[4*wordAddr_i+3] in bits 7:0
module ByteStorage #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic [AW-3:0] wordAddr_i,
  output logic [31:0]   word_o
);

  logic [7:0] bytes [0:BYTES-1];

  assign word_o = {bytes[{wordAddr_i, 2'd0}], bytes[{wordAddr_i, 2'd1}],
                   bytes[{wordAddr_i, 2'd2}], bytes[{wordAddr_i, 2'd3}]};

endmodule

// InstrMemory: instruction memory wrapper around the byte storage.
//   wordAddr_i - word index of the instruction to fetch
//   instr_o    - fetched instruction word
module InstrMemory #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic [AW-3:0] wordAddr_i,
  output logic [31:0]   instr_o
);

  ByteStorage #(.BYTES(BYTES)) storage (
    .wordAddr_i(wordAddr_i),
    .word_o    (instr_o)
  );

endmodule

// InstrFetchUnit: program counter, next-PC selection and instruction memory.
//   clk_i, reset_i - clock and synchronous reset (PC <- 0)
//   branchTaken_i  - conditional branch resolved as taken this cycle
//   jump_i         - unconditional jump this cycle
//   instr_o        - instruction at the current PC
module InstrFetchUnit #(
  parameter int IMEM_BYTES = 1024,
  parameter int AW         = $clog2(IMEM_BYTES)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        branchTaken_i,
  input  logic        jump_i,
  output logic [31:0] instr_o
);

  // Keeps the PC word aligned and inside the instruction memory so that
  // running off the end wraps back to address 0.
  localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1) & ~32'd3;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;

  assign pcPlus4      = pc_q + 32'd4;
  assign branchTarget = pcPlus4 + {{14{instr_o[15]}}, instr_o[15:0], 2'b00};
  assign jumpTarget   = {pcPlus4[31:28], instr_o[25:0], 2'b00};

  always_comb begin
    pc_d = pcPlus4;
    if (jump_i) begin
      pc_d = jumpTarget;
    end else if (branchTaken_i) begin
      pc_d = branchTarget;
    end
    pc_d = pc_d & PC_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  InstrMemory #(.BYTES(IMEM_BYTES)) imemory (
    .wordAddr_i(pc_q[AW-1:2]),
    .instr_o   (instr_o)
  );

endmodule

// RegisterFile: 32 x 32-bit registers, two combinational reads, one write.
//   clk_i, reset_i       - clock and synchronous reset (all registers <- 0)
//   we_i                 - write enable, committed on the rising edge
//   raddrA_i, raddrB_i   - read addresses
//   waddr_i, wdata_i     - write address and data
//   rdataA_o, rdataB_o   - read data ($0 always reads zero)
module RegisterFile (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [4:0]  raddrA_i,
  input  logic [4:0]  raddrB_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdataA_o,
  output logic [31:0] rdataB_o
);

  logic [31:0] registers [0:31];

  // Writes to $0 are dropped so that entry stays zero after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o = (raddrA_i == 5'd0) ? 32'd0 : registers[raddrA_i];
  assign rdataB_o = (raddrB_i == 5'd0) ? 32'd0 : registers[raddrB_i];

endmodule

// Alu: 32-bit wrapping arithmetic and logic unit.
//   a_i, b_i  - operands (b is the register or the extended immediate)
//   shamt_i   - shift amount for sll (applied to b)
//   op_i      - operation, one of MipsPkg::aluOp_e
//   result_o  - result
module Alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  logic [2:0]  op_i,
  output logic [31:0] result_o
);

  import MipsPkg::*;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_SLT:   result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLL:   result_o = b_i << shamt_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// ControlDecoder: opcode/funct to datapath controls.
//   opcode_i, funct_i - instruction fields
//   regWrite_o        - write the register file
//   regDst_o          - destination is rd (1) or rt (0)
//   aluSrcImm_o       - ALU operand b is the extended immediate
//   extMode_o         - immediate extension, one of MipsPkg::extMode_e
//   aluOp_o           - ALU operation, one of MipsPkg::aluOp_e
//   memWrite_o        - store word
//   memToReg_o        - write back load data instead of the ALU result
//   branchEq_o/Ne_o   - beq / bne
//   jump_o            - j
// Anything not recognised leaves every control at its default, i.e. a NOP.
module ControlDecoder (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       regWrite_o,
  output logic       regDst_o,
  output logic       aluSrcImm_o,
  output logic [1:0] extMode_o,
  output logic [2:0] aluOp_o,
  output logic       memWrite_o,
  output logic       memToReg_o,
  output logic       branchEq_o,
  output logic       branchNe_o,
  output logic       jump_o
);

  import MipsPkg::*;

  always_comb begin
    regWrite_o  = 1'b0;
    regDst_o    = 1'b0;
    aluSrcImm_o = 1'b0;
    extMode_o   = EXT_SIGN;
    aluOp_o     = ALU_ADD;
    memWrite_o  = 1'b0;
    memToReg_o  = 1'b0;
    branchEq_o  = 1'b0;
    branchNe_o  = 1'b0;
    jump_o      = 1'b0;
    case (opcode_i)
      6'h00: begin
        regDst_o = 1'b1;
        // add/sub share hardware with addu/subu: no overflow trap exists.
        case (funct_i)
          6'h20, 6'h21: begin regWrite_o = 1'b1; aluOp_o = ALU_ADD; end
          6'h22, 6'h23: begin regWrite_o = 1'b1; aluOp_o = ALU_SUB; end
          6'h24:        begin regWrite_o = 1'b1; aluOp_o = ALU_AND; end
          6'h25:        begin regWrite_o = 1'b1; aluOp_o = ALU_OR;  end
          6'h2A:        begin regWrite_o = 1'b1; aluOp_o = ALU_SLT; end
          6'h00:        begin regWrite_o = 1'b1; aluOp_o = ALU_SLL; end
          default:      regWrite_o = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
      end
      6'h0C: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
        extMode_o   = EXT_ZERO;
        aluOp_o     = ALU_AND;
      end
      6'h0D: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
        extMode_o   = EXT_ZERO;
        aluOp_o     = ALU_OR;
      end
      6'h0F: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
        extMode_o   = EXT_LUI;
        aluOp_o     = ALU_PASSB;
      end
      6'h0A: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
        aluOp_o     = ALU_SLT;
      end
      6'h23: begin
        regWrite_o  = 1'b1;
        aluSrcImm_o = 1'b1;
        memToReg_o  = 1'b1;
      end
      6'h2B: begin
        aluSrcImm_o = 1'b1;
        memWrite_o  = 1'b1;
      end
      6'h04:   branchEq_o = 1'b1;
      6'h05:   branchNe_o = 1'b1;
      6'h02:   jump_o     = 1'b1;
      default: regWrite_o = 1'b0;
    endcase
  end

endmodule

// DataMemory: big-endian word memory, combinational read, write on the edge.
// It has no reset: its contents survive a processor reset.
//   clk_i      - clock
//   we_i       - store word
//   wordAddr_i - word index (byte address bits above the two lsbs)
//   wdata_i    - store data
//   rdata_o    - load data
module DataMemory #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-3:0] wordAddr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] bytes [0:BYTES-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      bytes[{wordAddr_i, 2'd0}] <= wdata_i[31:24];
      bytes[{wordAddr_i, 2'd1}] <= wdata_i[23:16];
      bytes[{wordAddr_i, 2'd2}] <= wdata_i[15:8];
      bytes[{wordAddr_i, 2'd3}] <= wdata_i[7:0];
    end
  end

  assign rdata_o = {bytes[{wordAddr_i, 2'd0}], bytes[{wordAddr_i, 2'd1}],
                    bytes[{wordAddr_i, 2'd2}], bytes[{wordAddr_i, 2'd3}]};

endmodule

module mips_processor #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024
) (
  input  logic clk,
  input  logic reset
);

  import MipsPkg::*;

  localparam int DAW = $clog2(DMEM_BYTES);

  logic [31:0] instr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] extImm;
  logic [31:0] aluB;
  logic [31:0] aluResult;
  logic [31:0] memRdata;
  logic [31:0] wbData;
  logic [4:0]  writeReg;
  logic        regWrite;
  logic        regDst;
  logic        aluSrcImm;
  logic [1:0]  extMode;
  logic [2:0]  aluOp;
  logic        memWrite;
  logic        memToReg;
  logic        branchEq;
  logic        branchNe;
  logic        jump;
  logic        operandsEqual;
  logic        branchTaken;
  logic        commitRegWrite;
  logic        commitMemWrite;

  InstrFetchUnit #(.IMEM_BYTES(IMEM_BYTES)) IFU (
    .clk_i        (clk),
    .reset_i      (reset),
    .branchTaken_i(branchTaken),
    .jump_i       (jump),
    .instr_o      (instr)
  );

  ControlDecoder decoder (
    .opcode_i   (instr[31:26]),
    .funct_i    (instr[5:0]),
    .regWrite_o (regWrite),
    .regDst_o   (regDst),
    .aluSrcImm_o(aluSrcImm),
    .extMode_o  (extMode),
    .aluOp_o    (aluOp),
    .memWrite_o (memWrite),
    .memToReg_o (memToReg),
    .branchEq_o (branchEq),
    .branchNe_o (branchNe),
    .jump_o     (jump)
  );

  RegisterFile registers (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (commitRegWrite),
    .raddrA_i(instr[25:21]),
    .raddrB_i(instr[20:16]),
    .waddr_i (writeReg),
    .wdata_i (wbData),
    .rdataA_o(rsData),
    .rdataB_o(rtData)
  );

  // Immediate shaping for the I-type group: arithmetic and memory offsets
  // sign-extend, logical immediates zero-extend, lui moves it to the top half.
  always_comb begin
    extImm = {{16{instr[15]}}, instr[15:0]};
    case (extMode)
      EXT_ZERO: extImm = {16'd0, instr[15:0]};
      EXT_LUI:  extImm = {instr[15:0], 16'd0};
      default:  extImm = {{16{instr[15]}}, instr[15:0]};
    endcase
  end

  assign aluB = aluSrcImm ? extImm : rtData;

  Alu alu (
    .a_i     (rsData),
    .b_i     (aluB),
    .shamt_i (instr[10:6]),
    .op_i    (aluOp),
    .result_o(aluResult)
  );

  DataMemory #(.BYTES(DMEM_BYTES)) dmem (
    .clk_i     (clk),
    .we_i      (commitMemWrite),
    .wordAddr_i(aluResult[DAW-1:2]),
    .wdata_i   (rtData),
    .rdata_o   (memRdata)
  );

  assign wbData   = memToReg ? memRdata : aluResult;
  assign writeReg = regDst ? instr[15:11] : instr[20:16];

  assign operandsEqual = (rsData == rtData);
  assign branchTaken   = (branchEq && operandsEqual) || (branchNe && !operandsEqual);

  // A reset edge discards the instruction in flight instead of committing it.
  assign commitRegWrite = regWrite && !reset;
  assign commitMemWrite = memWrite && !reset;

endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed programs for mips_processor with hand-computed
// architectural results, read back through the design hierarchy.
module tb_mips_processor;

  logic clk;
  logic reset;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] prog [$];

  mips_processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
    .clk  (clk),
    .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] shamt,
                                       input logic [5:0] funct);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs n rising edges with reset low, then samples 1 time unit later.
  task automatic applyStimulus(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One edge with reset high, then checks PC and register file are cleared.
  task automatic resetEdge(input string tag);
    int nonZero;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    nonZero = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.registers.registers[i] !== 32'd0) nonZero++;
    end
    checkOutput({tag, ".pc"}, dut.IFU.pc_q, 32'd0);
    checkOutput({tag, ".nonZeroRegs"}, nonZero, 32'd0);
  endtask

  // Clears instruction memory, loads prog big-endian from address 0, resets.
  task automatic loadProgram(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) dut.IFU.imemory.storage.bytes[i] = 8'h00;
    for (int w = 0; w < prog.size(); w++) begin
      dut.IFU.imemory.storage.bytes[4*w]     = prog[w][31:24];
      dut.IFU.imemory.storage.bytes[4*w + 1] = prog[w][23:16];
      dut.IFU.imemory.storage.bytes[4*w + 2] = prog[w][15:8];
      dut.IFU.imemory.storage.bytes[4*w + 3] = prog[w][7:0];
    end
    resetEdge(tag);
  endtask

  function automatic logic [31:0] rf(input int idx);
    return dut.registers.registers[idx];
  endfunction

  initial begin
    reset = 1'b1;
    $display("[TB] starting mips_processor directed programs");

    // Subtract program.
    prog = {};
    prog.push_back(encI(6'h08, 5'd0, 5'd16, 16'd189));
    prog.push_back(encI(6'h08, 5'd0, 5'd17, 16'hFFE4));
    prog.push_back(encR(5'd16, 5'd17, 5'd8, 5'd0, 6'h22));
    prog.push_back(encR(5'd17, 5'd8, 5'd9, 5'd0, 6'h22));
    prog.push_back(encR(5'd8, 5'd8, 5'd10, 5'd0, 6'h22));
    prog.push_back(encR(5'd9, 5'd0, 5'd11, 5'd0, 6'h22));
    loadProgram("sub.reset");
    applyStimulus(6);
    checkOutput("sub.s0", rf(16), 32'd189);
    checkOutput("sub.s1", rf(17), 32'hFFFFFFE4);
    checkOutput("sub.t0", rf(8), 32'd217);
    checkOutput("sub.t1", rf(9), 32'hFFFFFF0B);
    checkOutput("sub.t2", rf(10), 32'd0);
    checkOutput("sub.t3", rf(11), 32'hFFFFFF0B);
    checkOutput("sub.pc", dut.IFU.pc_q, 32'h18);

    // Arithmetic, $0 and wrap past 0x7FFFFFFF.
    prog = {};
    prog.push_back(encI(6'h08, 5'd0, 5'd8, 16'd5));
    prog.push_back(encR(5'd8, 5'd8, 5'd0, 5'd0, 6'h20));
    prog.push_back(encR(5'd8, 5'd0, 5'd9, 5'd0, 6'h20));
    prog.push_back(encI(6'h0F, 5'd0, 5'd8, 16'h7FFF));
    prog.push_back(encI(6'h0D, 5'd8, 5'd8, 16'hFFFF));
    prog.push_back(encI(6'h08, 5'd8, 5'd8, 16'd1));
    loadProgram("arith.reset");
    applyStimulus(3);
    checkOutput("arith.zero", rf(0), 32'd0);
    checkOutput("arith.t1", rf(9), 32'd5);
    applyStimulus(2);
    checkOutput("arith.ori", rf(8), 32'h7FFFFFFF);
    applyStimulus(1);
    checkOutput("arith.wrap", rf(8), 32'h80000000);

    // Memory: store/load round trips and big-endian byte order.
    prog = {};
    prog.push_back(encI(6'h08, 5'd0, 5'd8, 16'h1234));
    prog.push_back(encI(6'h2B, 5'd0, 5'd8, 16'd8));
    prog.push_back(encI(6'h23, 5'd0, 5'd9, 16'd8));
    prog.push_back(encI(6'h0F, 5'd0, 5'd10, 16'hA1B2));
    prog.push_back(encI(6'h0D, 5'd10, 5'd10, 16'hC3D4));
    prog.push_back(encI(6'h08, 5'd0, 5'd16, 16'd20));
    prog.push_back(encI(6'h2B, 5'd16, 5'd10, 16'hFFF8));
    prog.push_back(encI(6'h23, 5'd0, 5'd11, 16'd12));
    loadProgram("mem.reset");
    applyStimulus(8);
    checkOutput("mem.t1", rf(9), 32'h00001234);
    checkOutput("mem.t3", rf(11), 32'hA1B2C3D4);
    checkOutput("mem.byte10", dut.dmem.bytes[10], 32'h12);
    checkOutput("mem.byte11", dut.dmem.bytes[11], 32'h34);
    checkOutput("mem.byte12", dut.dmem.bytes[12], 32'hA1);
    checkOutput("mem.byte15", dut.dmem.bytes[15], 32'hD4);

    // Control flow: beq taken, bne not taken, j forward.
    prog = {};
    prog.push_back(encI(6'h08, 5'd0, 5'd8, 16'd7));
    prog.push_back(encI(6'h08, 5'd0, 5'd9, 16'd7));
    prog.push_back(encI(6'h04, 5'd8, 5'd9, 16'd1));
    prog.push_back(encI(6'h08, 5'd0, 5'd10, 16'd1));
    prog.push_back(encI(6'h05, 5'd8, 5'd9, 16'd1));
    prog.push_back(encI(6'h08, 5'd0, 5'd11, 16'd2));
    prog.push_back(encJ(6'h02, 26'd8));
    prog.push_back(encI(6'h08, 5'd0, 5'd16, 16'd3));
    prog.push_back(encI(6'h08, 5'd0, 5'd17, 16'd4));
    loadProgram("flow.reset");
    checkOutput("flow.dmemKept", dut.dmem.bytes[12], 32'hA1);
    applyStimulus(3);
    checkOutput("flow.beqPc", dut.IFU.pc_q, 32'h10);
    applyStimulus(1);
    checkOutput("flow.bnePc", dut.IFU.pc_q, 32'h14);
    applyStimulus(2);
    checkOutput("flow.jPc", dut.IFU.pc_q, 32'h20);
    applyStimulus(1);
    checkOutput("flow.t2", rf(10), 32'd0);
    checkOutput("flow.t3", rf(11), 32'd2);
    checkOutput("flow.s0", rf(16), 32'd0);
    checkOutput("flow.s1", rf(17), 32'd4);
    checkOutput("flow.pc", dut.IFU.pc_q, 32'h24);

    // slt, slti, sll, logical immediates, NOPs and mid-program reset.
    prog = {};
    prog.push_back(encI(6'h08, 5'd0, 5'd8, 16'hFFFF));
    prog.push_back(encI(6'h08, 5'd0, 5'd9, 16'd1));
    prog.push_back(encR(5'd8, 5'd9, 5'd10, 5'd0, 6'h2A));
    prog.push_back(encR(5'd9, 5'd8, 5'd11, 5'd0, 6'h2A));
    prog.push_back(encI(6'h0A, 5'd8, 5'd16, 16'd0));
    prog.push_back(encR(5'd0, 5'd9, 5'd17, 5'd4, 6'h00));
    prog.push_back(encI(6'h3F, 5'd0, 5'd8, 16'h0055));
    prog.push_back(encR(5'd8, 5'd8, 5'd9, 5'd0, 6'h3F));
    prog.push_back(encI(6'h0C, 5'd8, 5'd18, 16'h00F0));
    prog.push_back(encI(6'h09, 5'd0, 5'd19, 16'hFFFE));
    loadProgram("slt.reset");
    applyStimulus(2);
    checkOutput("slt.preT0", rf(8), 32'hFFFFFFFF);
    checkOutput("slt.prePc", dut.IFU.pc_q, 32'h8);
    resetEdge("midReset");
    applyStimulus(3);
    checkOutput("rerun.t2", rf(10), 32'd1);
    checkOutput("rerun.pc", dut.IFU.pc_q, 32'hC);
    applyStimulus(7);
    checkOutput("slt.t0", rf(8), 32'hFFFFFFFF);
    checkOutput("slt.t1", rf(9), 32'd1);
    checkOutput("slt.t2", rf(10), 32'd1);
    checkOutput("slt.t3", rf(11), 32'd0);
    checkOutput("slti.s0", rf(16), 32'd1);
    checkOutput("sll.s1", rf(17), 32'd16);
    checkOutput("andi.s2", rf(18), 32'h000000F0);
    checkOutput("addiu.s3", rf(19), 32'hFFFFFFFE);
    checkOutput("slt.pc", dut.IFU.pc_q, 32'h28);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
